// File: rtl/moore_pkg.sv
// Shared helpers for the sequence detector: state sizing, the pattern-derived
// transition tables evaluated at elaboration, and the saturating counter step.
package moore_pkg;

    localparam int MAX_LEN = 16;

    function automatic int state_w(int len);
        return $clog2(len + 1);
    endfunction

    // Bit m of the pattern in arrival order (m = 0 is the first bit received).
    function automatic logic pat_bit(logic [MAX_LEN-1:0] pat, int len, int m);
        return logic'((pat >> (len - 1 - m)) & MAX_LEN'(1));
    endfunction

    // Progress after appending bit b to the first k matched pattern bits (k < len):
    // the longest pattern prefix that is a suffix of that string.
    function automatic int next_state(logic [MAX_LEN-1:0] pat, int len, int k, logic b);
        logic [MAX_LEN:0] s;
        logic             ok;
        int               res;
        s   = (MAX_LEN+1)'(b) << k;
        res = 0;
        for (int m = 0; m < k; m++)
            s = s | ((MAX_LEN+1)'(pat_bit(pat, len, m)) << m);
        for (int j = 1; j <= k + 1; j++) begin
            ok = 1'b1;
            for (int t = 0; t < j; t++)
                if (((s >> (k + 1 - j + t)) & (MAX_LEN+1)'(1)) != (MAX_LEN+1)'(pat_bit(pat, len, t)))
                    ok = 1'b0;
            if (ok) res = j;
        end
        return res;
    endfunction

    // Longest proper prefix of the pattern that is also a suffix of it.
    function automatic int border(logic [MAX_LEN-1:0] pat, int len);
        logic ok;
        int   res;
        res = 0;
        for (int j = 1; j < len; j++) begin
            ok = 1'b1;
            for (int t = 0; t < j; t++)
                if (pat_bit(pat, len, t) != pat_bit(pat, len, len - j + t)) ok = 1'b0;
            if (ok) res = j;
        end
        return res;
    endfunction

    function automatic logic [MAX_LEN-1:0] sat_inc(logic [MAX_LEN-1:0] v, int w);
        logic [MAX_LEN:0] max_v;
        max_v = ((MAX_LEN+1)'(1) << w) - (MAX_LEN+1)'(1);
        return ({1'b0, v} == max_v) ? v : v + MAX_LEN'(1);
    endfunction

endpackage

// File: rtl/moore_seq_detector_if.sv
// Control, per-lane serial inputs and status/counter outputs of the detector.
interface moore_seq_detector_if #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8
);
    logic                      en;
    logic                      clear;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in;
    logic [CHANNELS-1:0]       out_S;
    logic [CHANNELS*CNT_W-1:0] hit_cnt;
    logic                      any_hit;

    modport master (output en, clear, in_valid, in, input out_S, hit_cnt, any_hit);
    modport slave  (input en, clear, in_valid, in, output out_S, hit_cnt, any_hit);
endinterface

// File: rtl/moore_seq_lane.sv
// One detector lane: match-progress register driven by an elaboration-time
// transition table, Moore flag, and saturating hit counter.
module moore_seq_lane
    import moore_pkg::*;
#(
    parameter int             LEN     = 4,
    parameter logic [LEN-1:0] PATTERN = 4'b1011,
    parameter bit             OVERLAP = 1'b1,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_clear,
    input  logic             i_valid,
    input  logic             i_bit,
    output logic             o_flag,
    output logic [CNT_W-1:0] o_cnt
);
    localparam int ST_W    = state_w(LEN);
    localparam int TBL_N   = 2 ** (ST_W + 1);
    localparam int RESTART = OVERLAP ? border(MAX_LEN'(PATTERN), LEN) : 0;

    logic [ST_W-1:0]  r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [ST_W-1:0]  w_next_tbl [TBL_N];
    logic [ST_W-1:0]  w_next;

    // Table indexed by {state, bit}; a full match restarts from RESTART before
    // the new bit is applied, and unreachable encodings fall back to S0.
    for (genvar g = 0; g < TBL_N; g++) begin : g_tbl
        localparam int K    = g / 2;
        localparam int KEFF = (K >= LEN) ? RESTART : K;
        localparam int NXT  = (K > LEN) ? 0 : next_state(MAX_LEN'(PATTERN), LEN, KEFF, logic'(g % 2));
        assign w_next_tbl[g] = ST_W'(NXT);
    end

    assign w_next = w_next_tbl[{r_state, i_bit}];

    // NOTE: state and counter use non-blocking assignments so every lane
    // samples the pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= '0;
            r_cnt   <= '0;
        end else if (i_clear) begin
            r_state <= '0;
            r_cnt   <= '0;
        end else if (i_en && i_valid) begin
            r_state <= w_next;
            if (w_next == ST_W'(LEN))
                r_cnt <= CNT_W'(sat_inc(MAX_LEN'(r_cnt), CNT_W));
        end
    end

    assign o_flag = (r_state == ST_W'(LEN));
    assign o_cnt  = r_cnt;

endmodule

// File: rtl/moore_seq_detector.sv
// Multi-lane Moore sequence detector: CHANNELS independent lanes sharing one
// pattern, with a combined any-hit flag.
module moore_seq_detector #(
    parameter int             CHANNELS = 4,
    parameter int             LEN      = 4,
    parameter logic [LEN-1:0] PATTERN  = 4'b1011,
    parameter bit             OVERLAP  = 1'b1,
    parameter int             CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    moore_seq_detector_if.slave  bus
);
    logic [CHANNELS-1:0] w_flags;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        moore_seq_lane #(
            .LEN     (LEN),
            .PATTERN (PATTERN),
            .OVERLAP (OVERLAP),
            .CNT_W   (CNT_W)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .i_en    (bus.en),
            .i_clear (bus.clear),
            .i_valid (bus.in_valid[i]),
            .i_bit   (bus.in[i]),
            .o_flag  (w_flags[i]),
            .o_cnt   (bus.hit_cnt[i*CNT_W +: CNT_W])
        );
    end

    assign bus.out_S   = w_flags;
    assign bus.any_hit = |w_flags;

endmodule

// File: tb/tb_moore_seq_detector.sv
// Bench for moore_seq_detector: overlapping, non-overlapping and 2-bit-counter
// variants driven in lockstep and compared against a bit-history model.
module tb_moore_seq_detector;
    localparam int         CH  = 4;
    localparam int         LEN = 4;
    localparam logic [3:0] PAT = 4'b1011;
    localparam int         NV  = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          clear;
    logic [CH-1:0] in_valid;
    logic [CH-1:0] in_bits;

    int n_checks = 0;
    int n_errors = 0;

    moore_seq_detector_if #(.CHANNELS(CH), .CNT_W(8)) if_ov  ();
    moore_seq_detector_if #(.CHANNELS(CH), .CNT_W(8)) if_nov ();
    moore_seq_detector_if #(.CHANNELS(CH), .CNT_W(2)) if_sat ();

    assign if_ov.en        = en;
    assign if_ov.clear     = clear;
    assign if_ov.in_valid  = in_valid;
    assign if_ov.in        = in_bits;
    assign if_nov.en       = en;
    assign if_nov.clear    = clear;
    assign if_nov.in_valid = in_valid;
    assign if_nov.in       = in_bits;
    assign if_sat.en       = en;
    assign if_sat.clear    = clear;
    assign if_sat.in_valid = in_valid;
    assign if_sat.in       = in_bits;

    moore_seq_detector #(.CHANNELS(CH), .LEN(LEN), .PATTERN(PAT), .OVERLAP(1'b1), .CNT_W(8))
        dut_ov (.clk(clk), .reset(reset), .bus(if_ov.slave));
    moore_seq_detector #(.CHANNELS(CH), .LEN(LEN), .PATTERN(PAT), .OVERLAP(1'b0), .CNT_W(8))
        dut_nov (.clk(clk), .reset(reset), .bus(if_nov.slave));
    moore_seq_detector #(.CHANNELS(CH), .LEN(LEN), .PATTERN(PAT), .OVERLAP(1'b0), .CNT_W(2))
        dut_sat (.clk(clk), .reset(reset), .bus(if_sat.slave));

    always #5 clk = ~clk;

    // Model: last accepted bits per lane, bits seen since the last restart,
    // the detect flag and the counter.
    int unsigned m_hist [NV][CH];
    int          m_n    [NV][CH];
    bit          m_flag [NV][CH];
    int unsigned m_cnt  [NV][CH];
    int unsigned cnt_max [NV] = '{255, 255, 3};
    bit          ovl     [NV] = '{1'b1, 1'b0, 1'b0};
    int          cnt_w   [NV] = '{8, 8, 2};

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < NV; v++)
            for (int i = 0; i < CH; i++) begin
                m_hist[v][i] = 0;
                m_n[v][i]    = 0;
                m_flag[v][i] = 1'b0;
                m_cnt[v][i]  = 0;
            end
    endtask

    task automatic model_step();
        bit hit;
        if (!reset || clear) begin
            model_reset();
        end else if (en) begin
            for (int v = 0; v < NV; v++)
                for (int i = 0; i < CH; i++)
                    if (in_valid[i]) begin
                        m_hist[v][i] = ((m_hist[v][i] << 1) | int'(in_bits[i])) & 32'hF;
                        m_n[v][i]++;
                        hit = (m_n[v][i] >= LEN) && (m_hist[v][i] == int'(PAT));
                        m_flag[v][i] = hit;
                        if (hit) begin
                            if (m_cnt[v][i] < cnt_max[v]) m_cnt[v][i]++;
                            if (!ovl[v]) m_n[v][i] = 0;
                        end
                    end
        end
    endtask

    task automatic check_all();
        logic [CH-1:0] e_out [NV];
        logic [63:0]   e_cnt [NV];
        for (int v = 0; v < NV; v++) begin
            e_cnt[v] = '0;
            for (int i = 0; i < CH; i++) begin
                e_out[v][i] = m_flag[v][i];
                e_cnt[v]    = e_cnt[v] | (64'(m_cnt[v][i]) << (i * cnt_w[v]));
            end
        end
        check("ov_out_S",    64'(if_ov.out_S),    64'(e_out[0]));
        check("ov_hit_cnt",  64'(if_ov.hit_cnt),  e_cnt[0]);
        check("ov_any_hit",  64'(if_ov.any_hit),  64'(|e_out[0]));
        check("nov_out_S",   64'(if_nov.out_S),   64'(e_out[1]));
        check("nov_hit_cnt", 64'(if_nov.hit_cnt), e_cnt[1]);
        check("nov_any_hit", 64'(if_nov.any_hit), 64'(|e_out[1]));
        check("sat_out_S",   64'(if_sat.out_S),   64'(e_out[2]));
        check("sat_hit_cnt", 64'(if_sat.hit_cnt), e_cnt[2]);
        check("sat_any_hit", 64'(if_sat.any_hit), 64'(|e_out[2]));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic drive(logic e, logic c, logic [CH-1:0] v, logic [CH-1:0] d);
        en       = e;
        clear    = c;
        in_valid = v;
        in_bits  = d;
    endtask

    // Feeds n bits to lane 0, MSB of bits first.
    task automatic lane0_bits(logic [15:0] bits, int n);
        for (int k = n - 1; k >= 0; k--) begin
            drive(1'b1, 1'b0, 4'b0001, CH'((bits >> k) & 16'd1));
            cycle();
        end
    endtask

    task automatic do_clear();
        drive(1'b1, 1'b1, 4'b1111, 4'b1111);
        cycle();
    endtask

    initial begin
        model_reset();
        reset = 1'b0;
        drive(1'b1, 1'b0, 4'b0000, 4'b0000);

        // Reset held with random activity
        repeat (5) begin
            drive(1'($urandom), 1'($urandom), CH'($urandom), CH'($urandom));
            cycle();
            check("rst_out_S",   64'(if_ov.out_S),   64'd0);
            check("rst_hit_cnt", 64'(if_ov.hit_cnt), 64'd0);
            check("rst_any_hit", 64'(if_sat.any_hit), 64'd0);
        end
        reset = 1'b1;
        drive(1'b1, 1'b0, 4'b0000, 4'b0000);
        cycle();

        // Overlapping vs non-overlapping on stream 1,0,1,1,0,1,1
        do_clear();
        lane0_bits(16'b1011, 4);
        check("ov_bit4_flag",  64'(if_ov.out_S[0]),  64'd1);
        check("nov_bit4_flag", 64'(if_nov.out_S[0]), 64'd1);
        lane0_bits(16'b011, 3);
        check("ov_bit7_flag",  64'(if_ov.out_S[0]),     64'd1);
        check("ov_bit7_cnt",   64'(if_ov.hit_cnt[7:0]), 64'd2);
        check("nov_bit7_flag", 64'(if_nov.out_S[0]),    64'd0);
        check("nov_bit7_cnt",  64'(if_nov.hit_cnt[7:0]), 64'd1);

        // Gaps, en freeze and flag hold
        do_clear();
        lane0_bits(16'b10, 2);
        repeat (3) begin
            drive(1'b1, 1'b0, 4'b0000, CH'($urandom));
            cycle();
        end
        repeat (2) begin
            drive(1'b0, 1'b0, 4'b1111, 4'b0000);
            cycle();
        end
        lane0_bits(16'b11, 2);
        check("gap_flag", 64'(if_ov.out_S[0]), 64'd1);
        repeat (2) begin
            drive(1'b1, 1'b0, 4'b0000, 4'b1111);
            cycle();
        end
        check("gap_hold_flag", 64'(if_nov.out_S[0]), 64'd1);
        drive(1'b0, 1'b0, 4'b0001, 4'b0000);
        cycle();
        check("freeze_flag", 64'(if_ov.out_S[0]),     64'd1);
        check("freeze_cnt",  64'(if_ov.hit_cnt[7:0]), 64'd1);

        // Counter saturation at 2 bits
        do_clear();
        repeat (5) lane0_bits(16'b1011, 4);
        check("sat_cnt",     64'(if_sat.hit_cnt[1:0]), 64'd3);
        check("nosat_cnt",   64'(if_nov.hit_cnt[7:0]), 64'd5);
        lane0_bits(16'b1011, 4);
        check("sat_cnt_hold", 64'(if_sat.hit_cnt[1:0]), 64'd3);

        // Simultaneous completions on lanes 0 and 2, then clear with a bit
        do_clear();
        for (int k = 3; k >= 0; k--) begin
            drive(1'b1, 1'b0, 4'b1111, (k == 2) ? 4'b0000 : 4'b0101);
            cycle();
        end
        check("multi_out_S", 64'(if_ov.out_S),   64'h5);
        check("multi_any",   64'(if_ov.any_hit), 64'd1);
        check("multi_cnt",   64'(if_ov.hit_cnt), 64'h0001_0001);
        drive(1'b1, 1'b1, 4'b1111, 4'b1111);
        cycle();
        check("clr_out_S", 64'(if_ov.out_S),   64'd0);
        check("clr_cnt",   64'(if_ov.hit_cnt), 64'd0);
        lane0_bits(16'b011, 3);
        check("clr_from_s0", 64'(if_ov.out_S[0]), 64'd0);

        // Asynchronous reset mid-pattern discards progress
        do_clear();
        lane0_bits(16'b101, 3);
        @(negedge clk);
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        reset = 1'b1;
        lane0_bits(16'b1, 1);
        check("rst_mid_flag", 64'(if_ov.out_S[0]), 64'd0);

        // Randomised traffic
        repeat (1500) begin
            drive(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 63) == 0),
                  CH'($urandom), CH'($urandom));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/moore_seq_detector.md
# moore_seq_detector

Parametrised, multi-channel Moore sequence detector; successor to the team's single-bit two-state Moore block. Each of CHANNELS independent serial lanes tracks match progress against a programmable LEN-bit pattern, with optional overlapping detection, input qualification, and a saturating per-lane hit counter. It sits behind the lab's serial input front-end and drives status LEDs and counter readout.

## Interface
- CHANNELS, 4, number of independent lanes (1..16)
- LEN, 4, pattern length in bits (2..16)
- PATTERN, 4'b1011, LEN-bit pattern; MSB is the first bit received
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = lane restarts from empty after a match
- CNT_W, 8, hit counter width per lane (1..16)
- clk  input  1  single clock; all state changes on posedge
- reset  input  1  asynchronous, active-low; low forces all state and outputs to reset values immediately
- en  input  1  global enable; 0 freezes all lanes and counters
- clear  input  1  synchronous clear: all lanes to S0, all counters to 0
- in_valid  input  CHANNELS  per-lane bit qualifier
- in  input  CHANNELS  per-lane serial data bit
- out_S  output  CHANNELS  Moore detect flag; decoded from lane state only
- hit_cnt  output  CHANNELS*CNT_W  lane i counter at bits [i*CNT_W +: CNT_W]
- any_hit  output  1  OR of out_S

## Operation
- Per-lane states S0..S_LEN; Sk = first k pattern bits matched; state register width $clog2(LEN+1).
- out_S[i] = 1 iff lane i is in S_LEN; no dependence on in/in_valid.
- A bit is accepted on lane i when en=1, clear=0, in_valid[i]=1.
- From Sk, k<LEN: accepted bit equal to PATTERN[LEN-1-k] -> S(k+1); otherwise -> fallback F(k,bit) = longest proper pattern prefix that is a suffix of (matched prefix + bit) (KMP fallback).
- From S_LEN: OVERLAP=1 -> treat as state B, the longest proper prefix that is also a suffix of PATTERN, then apply the bit as above; OVERLAP=0 -> treat as S0, then apply the bit.
- No accepted bit: hold state, so out_S stays high until the next accepted bit.
- Counter increments by 1 on every transition into S_LEN, including S_LEN->S_LEN with OVERLAP=1 and a self-overlapping pattern; saturates at 2^CNT_W-1.
- Priority: reset > clear > en=0 (freeze) > accepted bit.
- Lanes fully independent; simultaneous completions on several lanes each count.

## Timing
- Reset values: every lane in S0, out_S=0, hit_cnt=0, any_hit=0.
- Latency: bit completing the pattern accepted at edge N -> out_S and hit_cnt updated after edge N, visible in cycle N+1.
- any_hit combinational from state registers; same cycle as out_S.
- Reset asserted mid-pattern: progress discarded; after release the first accepted bit is evaluated from S0.
- clear and accepted bit on the same edge: bit is discarded, lane goes to S0, counter goes to 0.
- No combinational path from in or in_valid to any output.

## Structure
- Package moore_pkg: state-width function, elaboration-time functions for the fallback table F(k,bit) and border B from PATTERN/LEN, and a saturating-increment function.
- Sub-module moore_seq_lane: one lane (state register, next-state logic, counter); the top instantiates CHANNELS copies via generate and ORs the flags.

## Test plan
- Reset: hold reset low with random in/in_valid -> out_S=0, hit_cnt=0, any_hit=0 throughout; release -> lanes in S0.
- Overlap, PATTERN=1011, OVERLAP=1, lane 0 valid stream 1,0,1,1,0,1,1 -> out_S[0] high in the cycles after bits 4 and 7; hit_cnt lane 0 = 2.
- Non-overlap, same stream, OVERLAP=0 -> one hit, after bit 4 only; hit_cnt = 1.
- Gaps: stream 1,0 then in_valid low 3 cycles, then 1,1 -> detection after the 4th accepted bit; out_S stays high through following in_valid-low cycles; en=0 mid-stream freezes state and counter.
- Saturation, CNT_W=2: 5 non-overlapping 1011 matches -> hit_cnt lane 0 = 3 and holds.
- Multi-lane and clear: lanes 0 and 2 complete on the same edge -> out_S=4'b0101, any_hit=1, both counters = 1; then clear with an accepted bit on the same edge -> all counters 0, all lanes in S0, bit ignored.
